decoder_8bits_scan: RTL
=======================

Name: decoder_8bits_scan

Overview:
- Registered 3-to-8 one-hot decoder with a hold mode and an auto-scan mode.
- It is the counterpart of the team's 8-to-3 one-hot encoder: a code goes in and a one-hot byte comes out.
- Used to drive digit/LED selects, either statically from a loaded code or by rotating the active bit on a timebase strobe.
- One clock domain; all outputs are registered.

Parameters:
- DWELL, 4, number of tick strobes per scan step; legal range 1..255, 0 is illegal.
- CW, 8, width of the internal dwell counter; must satisfy 2^CW > DWELL.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  capture code and enter HOLD.
- code  input  3  binary code to decode, sampled when load=1.
- scan_start  input  1  enter SCAN.
- stop  input  1  in SCAN, freeze to HOLD; in HOLD, clear to IDLE.
- tick  input  1  single-cycle timebase strobe.
- out_decod  output  8  one-hot decoded output.
- out_code  output  3  binary code currently decoded.
- busy  output  1  high while in SCAN.
- wrap  output  1  one-cycle pulse when a scan step goes from 7 to 0.

Behaviour:
- Reset: synchronous, active-high; rst sampled high on a rising clk edge forces the following register values:
  - state=IDLE, out_decod=8'h00, out_code=3'd0, busy=0, wrap=0, dwell counter=0.
  - rst overrides every other input in the same cycle, including mid-scan.
- All outputs are registered. A control sampled at edge N is visible immediately after edge N (1-cycle latency).
- Invariant in HOLD and SCAN: out_decod == (8'b1 << out_code), exactly one bit set. In IDLE: out_decod=0.
- Input priority within a cycle: rst > stop > load > scan_start > tick.
- IDLE:
  - load -> HOLD, out_code=code.
  - scan_start -> SCAN, out_code=0, counter=0.
  - stop and tick are ignored.
- HOLD:
  - stop -> IDLE, out_code=0.
  - load -> stay in HOLD, out_code=code.
  - scan_start -> SCAN, starting from the current out_code, counter=0.
  - tick is ignored.
- SCAN (busy=1):
  - stop -> HOLD, out_code unchanged, counter=0.
  - load -> HOLD, out_code=code, counter=0.
  - scan_start while already in SCAN: restart counter at 0, out_code unchanged.
  - tick with counter<DWELL-1 -> counter+1.
  - tick with counter==DWELL-1 -> counter=0, out_code=out_code+1 mod 8.
  - wrap=1 for exactly the cycle after a step from 7 to 0; otherwise wrap=0.
  - With DWELL=1, every tick steps.
- wrap is 0 in every state other than SCAN, and on any cycle where stop or load preempts the tick.
- Cycles without tick never advance the counter.
- Back-to-back ticks on consecutive cycles are legal.
- busy is a registered decode of state==SCAN.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, HOLD=2'd1, SCAN=2'd2 (2'd3 is unreachable and recovers to IDLE).
  - the one-hot width constant 8 and code width constant 3.
- One natural sub-module: decoder_3to8, a purely combinational binary-to-one-hot decoder, instantiated on the next-state out_code so that out_decod registers together with out_code.
- FSM, dwell counter and wrap logic stay in the top module.

Test Plan:
- Reset: drive rst=1 for 2 cycles, then release -> out_decod=8'h00, out_code=0, busy=0, wrap=0; ticks while in IDLE change nothing.
- Load: load=1 with code=5 -> next cycle out_decod=8'h20, out_code=5, busy=0; then stop=1 -> out_decod=8'h00.
- Scan with DWELL=4: from IDLE, pulse scan_start, then 32 ticks.
  - out_decod steps 01,02,04,…,80,01, advancing once every 4 ticks.
  - wrap pulses once, at the 80->01 step (tick 32).
- Priority: in SCAN at out_code=3, assert stop, load (code=6) and tick in the same cycle -> HOLD, out_code=3, out_decod=8'h08, wrap=0.
- Mid-scan reset: in SCAN at out_code=7 with counter=3, assert rst together with tick -> IDLE, out_decod=8'h00, wrap=0; no wrap pulse is ever seen.
- Resume from HOLD: load code=6, then scan_start, then 8 ticks (DWELL=4) -> out_decod goes 40 -> 80 -> 01 with wrap=1 on the 01 cycle; busy=1 throughout the scan.

Source files
------------

// File: rtl/decoder_8bits_scan_pkg.sv
// Shared types and widths for the scanning 3-to-8 decoder.
package decoder_8bits_scan_pkg;

    localparam int unsigned OneHotW = 8;
    localparam int unsigned CodeW   = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHold = 2'd1,
        StScan = 2'd2
    } state_e;

endpackage

// File: rtl/decoder_3to8.sv
// Combinational binary-to-one-hot decoder.
module decoder_3to8
    import decoder_8bits_scan_pkg::*;
(
    input  logic [CodeW-1:0]   code,
    output logic [OneHotW-1:0] onehot
);

    assign onehot = OneHotW'(1) << code;

endmodule

// File: rtl/decoder_8bits_scan.sv
// Registered 3-to-8 one-hot decoder with hold and tick-driven auto-scan modes.
module decoder_8bits_scan
    import decoder_8bits_scan_pkg::*;
#(
    parameter int unsigned DWELL = 4,
    parameter int unsigned CW    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [CodeW-1:0]   code,
    input  logic               scan_start,
    input  logic               stop,
    input  logic               tick,
    output logic [OneHotW-1:0] out_decod,
    output logic [CodeW-1:0]   out_code,
    output logic               busy,
    output logic               wrap
);

    localparam logic [CW-1:0]    DwellLast = CW'(DWELL - 1);
    localparam logic [CodeW-1:0] CodeLast  = '1;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CodeW-1:0]     code_d;
    logic [OneHotW-1:0]   onehot_d;
    logic [OneHotW-1:0]   decod_d;
    logic                 wrap_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = out_code;
        wrap_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (load) begin
                    state_d = StHold;
                    code_d  = code;
                end else if (scan_start) begin
                    state_d = StScan;
                    code_d  = '0;
                    cnt_d   = '0;
                end
            end
            StHold: begin
                if (stop) begin
                    state_d = StIdle;
                    code_d  = '0;
                    cnt_d   = '0;
                end else if (load) begin
                    code_d = code;
                end else if (scan_start) begin
                    state_d = StScan;
                    cnt_d   = '0;
                end
            end
            StScan: begin
                if (stop) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end else if (load) begin
                    state_d = StHold;
                    code_d  = code;
                    cnt_d   = '0;
                end else if (scan_start) begin
                    cnt_d = '0;
                end else if (tick) begin
                    if (cnt_q == DwellLast) begin
                        cnt_d  = '0;
                        code_d = out_code + 1'b1;
                        wrap_d = (out_code == CodeLast);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                // Unreachable encoding recovers to a clean idle.
                state_d = StIdle;
                code_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    decoder_3to8 u_dec (
        .code   (code_d),
        .onehot (onehot_d)
    );

    assign decod_d = (state_d == StIdle) ? '0 : onehot_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            out_code  <= '0;
            out_decod <= '0;
            busy      <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_code  <= code_d;
            out_decod <= decod_d;
            busy      <= (state_d == StScan);
            wrap      <= wrap_d;
        end
    end

endmodule
